// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the bfloat16 multiplier scheduler.
// Holds the default operand/error widths, the bfloat16 word type, the
// registered response record and the multiplier error codes.
package mul_sched_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int ERROR_WIDTH_DEF = 2;
  localparam int ID_WIDTH_MAX    = 3;   // enough for up to 8 requesters

  typedef logic [15:0] bf16_t;

  typedef struct packed {
    logic [ID_WIDTH_MAX-1:0]    id;
    bf16_t                      data;
    logic [ERROR_WIDTH_DEF-1:0] error;
  } rsp_t;

  // Multiplier error codes
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_NAN  = 2'b11;

  // Assemble a bfloat16 word from its fields
  function automatic bf16_t bf16_pack(input logic sgn, input logic [7:0] exp,
                                      input logic [6:0] man);
    return {sgn, exp, man};
  endfunction

endpackage

// File: rtl/iv_fp_mul.sv
// Team bfloat16 multiplier, purely combinational.
// Subnormal inputs are treated as zero and the mantissa is truncated.
// error: 00 ok, 01 overflow (result +/-inf), 10 underflow (result +/-0),
// 11 invalid (NaN input or inf*0; result is the canonical NaN 7FC0).
module iv_fp_mul
  import mul_sched_pkg::*;
(
  input  bf16_t      in1,
  input  bf16_t      in2,
  output bf16_t      out,
  output logic [1:0] error
);

  logic              sgn_s;
  logic [7:0]        ea_s, eb_s;
  logic [6:0]        ma_s, mb_s;
  logic              nan_a_s, nan_b_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;
  logic [15:0]       prod_s;
  logic signed [9:0] exp_raw_s;
  logic signed [9:0] exp_adj_s;
  logic [6:0]        man_s;

  assign sgn_s    = in1[15] ^ in2[15];
  assign ea_s     = in1[14:7];
  assign eb_s     = in2[14:7];
  assign ma_s     = in1[6:0];
  assign mb_s     = in2[6:0];
  assign nan_a_s  = (ea_s == 8'hFF) && (ma_s != 7'h00);
  assign nan_b_s  = (eb_s == 8'hFF) && (mb_s != 7'h00);
  assign inf_a_s  = (ea_s == 8'hFF) && (ma_s == 7'h00);
  assign inf_b_s  = (eb_s == 8'hFF) && (mb_s == 7'h00);
  assign zero_a_s = (ea_s == 8'h00);
  assign zero_b_s = (eb_s == 8'h00);

  // Mantissa product, normalisation and special-case selection
  always_comb begin
    prod_s    = {8'h00, 1'b1, ma_s} * {8'h00, 1'b1, mb_s};
    exp_raw_s = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - 10'sd127;
    if (prod_s[15]) begin
      man_s     = prod_s[14:8];
      exp_adj_s = exp_raw_s + 10'sd1;
    end else begin
      man_s     = prod_s[13:7];
      exp_adj_s = exp_raw_s;
    end

    if (nan_a_s || nan_b_s || (inf_a_s && zero_b_s) || (zero_a_s && inf_b_s)) begin
      out   = 16'h7FC0;
      error = ERR_NAN;
    end else if (inf_a_s || inf_b_s) begin
      out   = bf16_pack(sgn_s, 8'hFF, 7'h00);
      error = ERR_NONE;
    end else if (zero_a_s || zero_b_s) begin
      out   = bf16_pack(sgn_s, 8'h00, 7'h00);
      error = ERR_NONE;
    end else if (exp_adj_s >= 10'sd255) begin
      out   = bf16_pack(sgn_s, 8'hFF, 7'h00);
      error = ERR_OVF;
    end else if (exp_adj_s <= 10'sd0) begin
      out   = bf16_pack(sgn_s, 8'h00, 7'h00);
      error = ERR_UNF;
    end else begin
      out   = bf16_pack(sgn_s, exp_adj_s[7:0], man_s);
      error = ERR_NONE;
    end
  end

endmodule

// File: rtl/mul_sched_rr_arb.sv
// Round-robin arbiter for the multiplier scheduler.
// The search starts at ptr and wraps; the winner's successor becomes the
// next pointer. With en low or no request, grant is zero and ptr holds.
module mul_sched_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     next_ptr
);

  logic [IDW-1:0] idx_s;
  logic           found_s;

  // Rotating priority search, first requester at or after ptr wins
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found_s  = 1'b0;
    idx_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = IDW'((int'(ptr) + k) % NUM_REQ);
      if (en && !found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
        next_ptr     = IDW'((int'(idx_s) + 1) % NUM_REQ);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mul_sched.sv
// Two-stage scheduler sharing one bfloat16 multiplier among NUM_REQ
// requesters. S1 captures the granted operands, the multiplier sits
// between S1 and S2, and S2 drives the registered response.
// Define MUL_SCHED_STATS_EN to build the saturating op/error counters;
// without it op_cnt and err_cnt are tied to zero.
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ERROR_WIDTH = ERROR_WIDTH_DEF,
  parameter int IDW         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ERROR_WIDTH-1:0]        rsp_error,
  output logic [15:0]                   op_cnt,
  output logic [15:0]                   err_cnt
);

  logic [NUM_REQ-1:0]    grant_s;
  logic [IDW-1:0]        ptr_r, next_ptr_s, gnt_id_s;
  logic                  adv_s, grant_en_s, any_grant_s;
  logic [DATA_WIDTH-1:0] gnt_a_s, gnt_b_s;
  logic                  s1_valid_r;
  logic [DATA_WIDTH-1:0] s1_a_r, s1_b_r;
  logic [IDW-1:0]        s1_id_r;
  logic                  rsp_valid_r;
  rsp_t                  rsp_r;
  bf16_t                 mul_out_s;
  logic [1:0]            mul_err_s;

  // S2 can take a new value when empty or being drained; S1 moves with it
  assign adv_s       = !rsp_valid_r || rsp_ready;
  // Accept only outside reset and when S1 has room this cycle
  assign grant_en_s  = rst_n && (!s1_valid_r || adv_s);
  assign any_grant_s = |grant_s;
  assign req_ready   = grant_s;

  mul_sched_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req      (req_valid),
    .ptr      (ptr_r),
    .en       (grant_en_s),
    .grant    (grant_s),
    .next_ptr (next_ptr_s)
  );

  // Select the granted requester's index and operands
  always_comb begin
    gnt_id_s = '0;
    gnt_a_s  = '0;
    gnt_b_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        gnt_id_s = IDW'(i);
        gnt_a_s  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_b_s  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        gnt_id_s = gnt_id_s;
      end
    end
  end

  // Round-robin pointer; the arbiter returns ptr unchanged when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= next_ptr_s;
    end
  end

  // S1: granted operands and requester index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_id_r    <= '0;
    end else if (any_grant_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= gnt_a_s;
      s1_b_r     <= gnt_b_s;
      s1_id_r    <= gnt_id_s;
    end else if (adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  iv_fp_mul u_mul (
    .in1   (bf16_t'(s1_a_r)),
    .in2   (bf16_t'(s1_b_r)),
    .out   (mul_out_s),
    .error (mul_err_s)
  );

  // S2: registered multiplier result, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_r       <= '0;
    end else if (adv_s) begin
      rsp_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        rsp_r.id    <= ID_WIDTH_MAX'(s1_id_r);
        rsp_r.data  <= mul_out_s;
        rsp_r.error <= mul_err_s;
      end
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = IDW'(rsp_r.id);
  assign rsp_data  = DATA_WIDTH'(rsp_r.data);
  assign rsp_error = ERROR_WIDTH'(rsp_r.error);

`ifdef MUL_SCHED_STATS_EN
  logic [15:0] op_cnt_r, err_cnt_r;

  // Saturating counts of completed operations and of erroneous ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_cnt_r  <= 16'h0000;
      err_cnt_r <= 16'h0000;
    end else if (rsp_valid_r && rsp_ready) begin
      if (op_cnt_r != 16'hFFFF) begin
        op_cnt_r <= op_cnt_r + 16'd1;
      end
      if ((rsp_r.error != 2'b00) && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  assign op_cnt  = op_cnt_r;
  assign err_cnt = err_cnt_r;
`else
  assign op_cnt  = 16'h0000;
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mul_sched.sv
// Directed self-checking bench for mul_sched (NUM_REQ=4, bfloat16).
// Expected values are hand-computed bfloat16 products and grant orders.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 1 time unit after that.
module tb_mul_sched;

  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int EW  = 2;
  localparam int IDW = 2;
`ifdef MUL_SCHED_STATS_EN
  localparam logic STATS = 1'b1;
`else
  localparam logic STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*DW-1:0] req_a, req_b;
  logic            rsp_valid, rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [DW-1:0]   rsp_data;
  logic [EW-1:0]   rsp_error;
  logic [15:0]     op_cnt, err_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mul_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ERROR_WIDTH(EW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error),
    .op_cnt    (op_cnt),
    .err_cnt   (err_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_rsp(input string tag, input logic [IDW-1:0] id, input logic [15:0] data);
    check_eq({tag, ".valid"}, rsp_valid, 1'b1);
    check_eq({tag, ".id"}, rsp_id, id);
    check_eq({tag, ".data"}, rsp_data, data);
  endtask

  // a, b, expected product, expected error
  logic [15:0] va [10] = '{16'h4040, 16'h3FC0, 16'hBF80, 16'h7F00, 16'h0080,
                           16'h7FC0, 16'h0000, 16'h3F80, 16'h4000, 16'hC000};
  logic [15:0] vb [10] = '{16'h4000, 16'h3FC0, 16'h4000, 16'h7F00, 16'h0080,
                           16'h3F80, 16'h4000, 16'h3F80, 16'h4000, 16'hC000};
  logic [15:0] vr [10] = '{16'h40C0, 16'h4010, 16'hC000, 16'h7F80, 16'h0000,
                           16'h7FC0, 16'h0000, 16'h3F80, 16'h4080, 16'h4080};
  logic [1:0]  ve [10] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10,
                           2'b11, 2'b00, 2'b00, 2'b00, 2'b00};

  initial begin
    // Reset values, and no accept while reset is asserted
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    step();
    step();
    check_eq("rst.req_ready", req_ready, 4'b0000);
    check_eq("rst.rsp_valid", rsp_valid, 1'b0);
    check_eq("rst.rsp_id", rsp_id, 2'd0);
    check_eq("rst.rsp_data", rsp_data, 16'h0000);
    check_eq("rst.rsp_error", rsp_error, 2'b00);
    check_eq("rst.op_cnt", op_cnt, 16'h0000);
    check_eq("rst.err_cnt", err_cnt, 16'h0000);

    // Single requester 2: 1.0 * 2.0 with two-cycle latency
    rst_n     = 1'b1;
    req_valid = 4'b0100;
    set_op(2, 16'h3F80, 16'h4000);
    settle();
    check_eq("single.req_ready", req_ready, 4'b0100);
    step();
    req_valid = 4'b0000;
    settle();
    check_eq("single.ready_drop", req_ready, 4'b0000);
    check_eq("single.lat1_valid", rsp_valid, 1'b0);
    step();
    check_rsp("single.rsp", 2'd2, 16'h4000);
    check_eq("single.rsp_error", rsp_error, 2'b00);
    step();
    check_eq("single.drained", rsp_valid, 1'b0);

    // All requesters held: round-robin 0,1,2,3,0,1 and in-order responses
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, 16'h3F80, 16'h4000 + 16'(i * 16));
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      settle();
      check_eq($sformatf("rr.grant%0d", k), req_ready, 4'b0001 << (k % 4));
      if (k >= 2) check_rsp($sformatf("rr.rsp%0d", k), 2'((k - 2) % 4), 16'h4000 + 16'(((k - 2) % 4) * 16));
      else check_eq($sformatf("rr.empty%0d", k), rsp_valid, 1'b0);
      step();
    end
    req_valid = 4'h0;
    settle();
    check_rsp("rr.tail0", 2'd0, 16'h4000);
    step();
    check_rsp("rr.tail1", 2'd1, 16'h4010);
    step();
    check_eq("rr.tail_empty", rsp_valid, 1'b0);

    // Consumer stall: two grants fill the pipe, then accept stops
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    settle();
    check_eq("stall.grant0", req_ready, 4'b0001);
    step();
    check_eq("stall.grant1", req_ready, 4'b0010);
    step();
    for (int k = 2; k < 5; k++) begin
      check_eq($sformatf("stall.noready%0d", k), req_ready, 4'b0000);
      check_rsp($sformatf("stall.hold%0d", k), 2'd0, 16'h4000);
      step();
    end
    rsp_ready = 1'b1;
    settle();
    check_eq("stall.resume_grant", req_ready, 4'b0100);
    check_rsp("stall.rsp0", 2'd0, 16'h4000);
    step();
    req_valid = 4'h0;
    settle();
    check_rsp("stall.rsp1", 2'd1, 16'h4010);
    step();
    check_rsp("stall.rsp2", 2'd2, 16'h4020);
    step();
    check_eq("stall.drained", rsp_valid, 1'b0);

    // Reset with S1 and S2 both occupied discards everything
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    step();
    step();
    check_eq("midrst.full", rsp_valid, 1'b1);
    rst_n = 1'b0;
    settle();
    check_eq("midrst.req_ready", req_ready, 4'b0000);
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    settle();
    check_eq("midrst.rsp_valid", rsp_valid, 1'b0);
    check_eq("midrst.op_cnt", op_cnt, 16'h0000);
    check_eq("midrst.lowest", req_ready, 4'b0010);
    step();
    req_valid = 4'h0;
    settle();
    check_eq("midrst.no_stale", rsp_valid, 1'b0);
    step();
    check_rsp("midrst.rsp", 2'd1, 16'h4010);
    step();
    check_eq("midrst.drained", rsp_valid, 1'b0);

    // Multiplier vectors incl. overflow, underflow, NaN; 10 ops, 3 errors
    do_reset();
    rsp_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      set_op(0, va[v], vb[v]);
      req_valid = 4'b0001;
      step();
      req_valid = 4'b0000;
      step();
      check_eq($sformatf("mul%0d.valid", v), rsp_valid, 1'b1);
      check_eq($sformatf("mul%0d.data", v), rsp_data, vr[v]);
      check_eq($sformatf("mul%0d.error", v), rsp_error, ve[v]);
    end
    step();
    check_eq("stats.op_cnt", op_cnt, STATS ? 16'd10 : 16'd0);
    check_eq("stats.err_cnt", err_cnt, STATS ? 16'd3 : 16'd0);

`ifdef MUL_SCHED_STATS_EN
    // Stream enough operations to reach the saturation point
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, 16'h3F80, 16'h3F80);
    req_valid = 4'hF;
    repeat (65540) step();
    check_eq("stats.op_sat", op_cnt, 16'hFFFF);
    check_eq("stats.err_none", err_cnt, 16'h0000);
    req_valid = 4'h0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
